// File: rtl/unpool_upsample_stream.sv
// rtl/unpool_upsample_stream.sv - streaming 2x nearest-neighbour upsampler (one channel, raster in/out)
//
// Purpose:
//   Accepts an InputH x InputW pixel raster and emits a (2*InputH) x (2*InputW)
//   raster in which every input pixel covers a 2x2 output block. Each input row
//   is captured in a line buffer and then replayed twice (EMIT_A, EMIT_B). In
//   each replay, every pixel is sent twice in a row.
//
// Optional feature (macro UNPOOL_PINGPONG_EN):
//   When defined, two line buffers are used. The next row loads while the
//   current row is being emitted, and rows chain back-to-back without a bubble.
//   When undefined, a single buffer is used and input is blocked during emission.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input pixel, raster order
//   in_valid   in_data valid
//   in_ready   block can accept in_data this cycle
//   out_data   upsampled pixel, raster order (registered)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_last   high with final pixel of the output frame (registered)
//   busy       high from first accepted input pixel until final output beat accepted

module unpool_upsample_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int InputH     = 14,
   parameter int InputW     = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy
);

   localparam int CW = $clog2(InputW);
   // Beat index covers 0..2*InputW-1, which always needs exactly one more bit than the column.
   localparam int KW = CW + 1;
   localparam int RW = (InputH > 1) ? $clog2(InputH) : 1;

   localparam logic [CW-1:0] WC_LAST = CW'(InputW - 1);
   localparam logic [KW-1:0] K_LAST  = KW'(2 * InputW - 1);
   localparam logic [RW-1:0] RC_LAST = RW'(InputH - 1);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_EMIT_A = 2'd1,
      S_EMIT_B = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]         wc;
   logic [KW-1:0]         k;
   logic [RW-1:0]         rc;
   logic [KW-1:0]         k_inc;
   logic [CW-1:0]         rd_col;
   logic [DATA_WIDTH-1:0] rd_pix;

   logic in_acc;
   logic out_acc;
   logic row_in_done;
   logic beat_last;
   logic row_out_done;
   logic can_start;
   logic can_chain;
   logic start_emit;
   logic frame_idle_end;

   logic [DATA_WIDTH-1:0] line_a [InputW];

`ifdef UNPOOL_PINGPONG_EN
   logic [DATA_WIDTH-1:0] line_b [InputW];
   logic [1:0]            full;
   logic                  wb;
   logic                  eb;
   logic                  rd_sel;
`endif

   // ------------------------------------------------------------------
   // Handshake and sequencing conditions
   // ------------------------------------------------------------------
   assign in_acc       = in_valid & in_ready;
   assign out_acc      = out_valid & out_ready;
   assign row_in_done  = in_acc & (wc == WC_LAST);
   assign beat_last    = (k == K_LAST);
   assign row_out_done = out_acc & beat_last & (state == S_EMIT_B);
   assign out_valid    = (state != S_LOAD);
   assign k_inc        = k + 1'b1;

   // Column of the beat that will be presented after the current transition:
   // beat 0 of a fresh pass, or (k+1)>>1 while walking through a pass.
   assign rd_col = (start_emit || ((state == S_EMIT_A) && beat_last)) ? '0 : k_inc[KW-1:1];

`ifdef UNPOOL_PINGPONG_EN
   assign in_ready  = rst_n & ~full[wb];
   // Bypass the full flag on the cycle the last pixel lands so emission
   // starts the very next cycle; column 0 is already stored because InputW >= 2.
   assign can_start = full[eb] | (row_in_done & (wb == eb));
   assign can_chain = full[~eb] | (row_in_done & (wb != eb));
   assign rd_sel    = (start_emit && (state == S_EMIT_B)) ? ~eb : eb;
   assign rd_pix    = rd_sel ? line_b[rd_col] : line_a[rd_col];
`else
   assign in_ready  = rst_n & (state == S_LOAD);
   assign can_start = row_in_done;
   assign can_chain = 1'b0;
   assign rd_pix    = line_a[rd_col];
`endif

   // Frame ends with nothing of the next frame already in flight.
   assign frame_idle_end = out_acc & out_last & ~can_chain & (wc == '0);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start_emit = 1'b0;
      case (state)
         S_LOAD: begin
            if (can_start) begin
               state_nxt  = S_EMIT_A;
               start_emit = 1'b1;
            end
         end
         S_EMIT_A: begin
            if (out_acc && beat_last) begin
               state_nxt = S_EMIT_B;
            end
         end
         S_EMIT_B: begin
            if (out_acc && beat_last) begin
               if (can_chain) begin
                  state_nxt  = S_EMIT_A;
                  start_emit = 1'b1;
               end else begin
                  state_nxt = S_LOAD;
               end
            end
         end
         default: begin
            state_nxt = S_LOAD;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counters and output register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wc       <= '0;
         k        <= '0;
         rc       <= '0;
         out_data <= '0;
         out_last <= 1'b0;
         busy     <= 1'b0;
      end else begin
         if (in_acc) begin
            wc <= (wc == WC_LAST) ? '0 : wc + 1'b1;
         end

         if (start_emit) begin
            k        <= '0;
            out_data <= rd_pix;
            out_last <= 1'b0;
         end else if (out_acc) begin
            k <= beat_last ? '0 : k_inc;
            // After the final beat of a row with nothing to chain, out_data
            // simply holds; out_valid drops with the state change.
            if (!row_out_done) begin
               out_data <= rd_pix;
            end
            out_last <= (state == S_EMIT_B) && (k_inc == K_LAST) && (rc == RC_LAST);
         end

         if (row_out_done) begin
            rc <= (rc == RC_LAST) ? '0 : rc + 1'b1;
         end

         busy <= in_acc | (busy & ~frame_idle_end);
      end
   end

`ifdef UNPOOL_PINGPONG_EN
   // Buffer ownership: wb is being written, eb is being (or next to be) emitted.
   // A buffer under emission is always marked full, so wb never equals eb
   // while a pixel is accepted during emission.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 2'b00;
         wb   <= 1'b0;
         eb   <= 1'b0;
      end else begin
         if (row_in_done) begin
            full[wb] <= 1'b1;
            wb       <= ~wb;
         end
         if (row_out_done) begin
            full[eb] <= 1'b0;
            eb       <= ~eb;
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Line buffer storage (contents are don't-care after reset)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (in_acc) begin
`ifdef UNPOOL_PINGPONG_EN
         if (wb) begin
            line_b[wc] <= in_data;
         end else begin
            line_a[wc] <= in_data;
         end
`else
         line_a[wc] <= in_data;
`endif
      end
   end

endmodule
